// File: rtl/lcd_pkg.sv
// Shared encodings, bar colours and default 800x480 timing for the LCD
// timing / test-pattern generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        PAT_BAR   = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 43;
    localparam int DEF_H_FP     = 210;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 8;
    localparam int DEF_V_FP     = 45;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_timing_pattern_gen_if.sv
// RGB LCD pin bundle plus the early active-region side channel for
// downstream video sources.
interface lcd_timing_pattern_gen_if #(
    parameter int CNT_W = 12
);
    logic             LCD_HSYNC;
    logic             LCD_VSYNC;
    logic             LCD_DE;
    logic [4:0]       LCD_R;
    logic [5:0]       LCD_G;
    logic [4:0]       LCD_B;
    logic             de_early;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             frame_start;

    modport master (
        output LCD_HSYNC, LCD_VSYNC, LCD_DE, LCD_R, LCD_G, LCD_B,
        output de_early, x, y, frame_start
    );

    modport slave (
        input LCD_HSYNC, LCD_VSYNC, LCD_DE, LCD_R, LCD_G, LCD_B,
        input de_early, x, y, frame_start
    );
endinterface

// File: rtl/lcd_sync_counter.sv
// Horizontal/vertical raster counters with stage-0 sync, active-region
// and coordinate decode.
module lcd_sync_counter #(
    parameter int H_ACTIVE = 800,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int H_FP     = 210,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 8,
    parameter int V_FP     = 45,
    parameter int CNT_W    = 12
) (
    input  logic             PixelClk,
    input  logic             RST,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs0,
    output logic             vs0,
    output logic             de_early,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] H_SYNC_W = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_W = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ASTART = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_AEND   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ASTART = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_AEND   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic hact;
    logic vact;

    // The line counter advances only on the pixel wrap, so both wrap together
    // at the last pixel of the last line.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        hs0      = (h_cnt < H_SYNC_W);
        vs0      = (v_cnt < V_SYNC_W);
        hact     = (h_cnt >= H_ASTART) && (h_cnt < H_AEND);
        vact     = (v_cnt >= V_ASTART) && (v_cnt < V_AEND);
        de_early = hact && vact;
        x        = de_early ? (h_cnt - H_ASTART) : '0;
        y        = de_early ? (v_cnt - V_ASTART) : '0;
    end

endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised RGB565 LCD timing generator with colour-bar, gray-ramp,
// grid and solid test patterns; every LCD output is one cycle behind the counters.
module lcd_timing_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int H_FP       = DEF_H_FP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int V_FP       = DEF_V_FP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int GRID       = 32,
    parameter int RAMP_SHIFT = 2,
    parameter int CNT_W      = 12
) (
    input  logic                       PixelClk,
    input  logic                       RST,
    input  logic [1:0]                 mode,
    input  logic [15:0]                solid_rgb,
    lcd_timing_pattern_gen_if.master   lcd
);
    localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic [CNT_W-1:0] GRID_LAST = CNT_W'(GRID - 1);
    localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt, x0, y0;
    logic             hs0, vs0, de0, frame0;
    pattern_e         mode_sh;
    logic [15:0]      solid_sh;
    logic [2:0]       bar_idx;
    logic [CNT_W-1:0] bar_cnt, col_mod, row_mod;
    logic [7:0]       g8;
    logic             grid_on;
    logic [15:0]      pix;

    lcd_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
        .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP),
        .CNT_W(CNT_W)
    ) u_sync (
        .PixelClk(PixelClk), .RST(RST),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .hs0(hs0), .vs0(vs0),
        .de_early(de0), .x(x0), .y(y0)
    );

    assign frame0       = (h_cnt == '0) && (v_cnt == '0);
    assign lcd.de_early = de0;
    assign lcd.x        = x0;
    assign lcd.y        = y0;

    // Bar index and column phase track the current stage-0 pixel; both sit at
    // zero outside the active region so every line starts from bar 0 / column 0.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            mode_sh  <= PAT_BAR;
            solid_sh <= '0;
            bar_idx  <= '0;
            bar_cnt  <= '0;
            col_mod  <= '0;
            row_mod  <= '0;
        end else begin
            if (frame0) begin
                mode_sh  <= pattern_e'(mode);
                solid_sh <= solid_rgb;
            end
            if (!de0) begin
                bar_idx <= '0;
                bar_cnt <= '0;
                col_mod <= '0;
            end else begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + CNT_W'(1);
                end
                col_mod <= (col_mod == GRID_LAST) ? '0 : col_mod + CNT_W'(1);
            end
            if (frame0)
                row_mod <= '0;
            else if (de0 && (x0 == X_LAST))
                row_mod <= (row_mod == GRID_LAST) ? '0 : row_mod + CNT_W'(1);
        end
    end

    always_comb begin
        g8      = 8'(x0 >> RAMP_SHIFT);
        grid_on = (col_mod == '0) || (row_mod == '0) || (x0 == X_LAST) || (y0 == Y_LAST);
        case (mode_sh)
            PAT_BAR:  pix = bar_colour(bar_idx);
            PAT_RAMP: pix = {g8[7:3], g8[7:2], g8[7:3]};
            PAT_GRID: pix = grid_on ? RGB_WHITE : RGB_BLACK;
            default:  pix = solid_sh;
        endcase
    end

    // Stage-1 pin registers; RGB is blanked here so it can never leak outside DE.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            lcd.LCD_HSYNC   <= ~HS_POL;
            lcd.LCD_VSYNC   <= ~VS_POL;
            lcd.LCD_DE      <= 1'b0;
            lcd.LCD_R       <= '0;
            lcd.LCD_G       <= '0;
            lcd.LCD_B       <= '0;
            lcd.frame_start <= 1'b0;
        end else begin
            lcd.LCD_HSYNC   <= hs0 ? HS_POL : ~HS_POL;
            lcd.LCD_VSYNC   <= vs0 ? VS_POL : ~VS_POL;
            lcd.LCD_DE      <= de0;
            {lcd.LCD_R, lcd.LCD_G, lcd.LCD_B} <= de0 ? pix : 16'h0000;
            lcd.frame_start <= frame0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed-vector bench for lcd_timing_pattern_gen on a small 42x20 raster so
// several whole frames fit in a short run.
module tb_lcd_timing_pattern_gen;
    import lcd_pkg::*;

    localparam int HA = 42, HS = 2, HBP = 3, HFP = 5;
    localparam int VA = 20, VS = 2, VBP = 2, VFP = 3;
    localparam int GR = 8, CW = 12;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int FRAME = HT * VT;
    localparam int HA0 = HS + HBP;
    localparam int VA0 = VS + VBP;

    typedef struct {
        int          pos;
        logic [1:0]  nextMode;
        logic [15:0] nextSolid;
        logic [15:0] expRgb;
        logic        expDe;
    } vec_t;

    logic        PixelClk = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;

    int testsRun = 0;
    int testsFailed = 0;
    int edgeCnt = 0;

    lcd_timing_pattern_gen_if #(.CNT_W(CW)) lcd ();
    lcd_timing_pattern_gen_if #(.CNT_W(CW)) lcdInv ();

    lcd_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP),
        .HS_POL(1'b0), .VS_POL(1'b0), .GRID(GR), .RAMP_SHIFT(2), .CNT_W(CW)
    ) dut (
        .PixelClk(PixelClk), .RST(RST), .mode(mode), .solid_rgb(solid_rgb), .lcd(lcd)
    );

    lcd_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP),
        .HS_POL(1'b1), .VS_POL(1'b1), .GRID(GR), .RAMP_SHIFT(2), .CNT_W(CW)
    ) dutInv (
        .PixelClk(PixelClk), .RST(RST), .mode(mode), .solid_rgb(solid_rgb), .lcd(lcdInv)
    );

    always #5 PixelClk = ~PixelClk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] s);
        mode      = m;
        solid_rgb = s;
    endtask

    // Advance to 1 time unit after edge n counted from reset release.
    task automatic gotoEdge(input int n);
        if (n < edgeCnt) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ordering: target edge %0d, already at %0d", n, edgeCnt);
        end
        while (edgeCnt < n) begin
            @(posedge PixelClk);
            #1;
            edgeCnt++;
        end
    endtask

    function automatic vec_t av(int f, int yy, int xx, logic [1:0] m, logic [15:0] s, logic [15:0] rgb);
        vec_t v;
        v.pos = f * FRAME + (yy + VA0) * HT + (xx + HA0);
        v.nextMode = m; v.nextSolid = s; v.expRgb = rgb; v.expDe = 1'b1;
        return v;
    endfunction

    function automatic vec_t pv(int f, int vv, int hh, logic [1:0] m, logic [15:0] s);
        vec_t v;
        v.pos = f * FRAME + vv * HT + hh;
        v.nextMode = m; v.nextSolid = s; v.expRgb = 16'h0000; v.expDe = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] rgbOf(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        return {r, g, b};
    endfunction

    initial begin
        vec_t vecs[$];
        int hsLow, vsLow, hsInvHigh, syncErr, deHigh, run, maxRun, lines;
        int rgbBad, fsCnt, deErr, xyErr, deEarlyCnt;
        int p, ph, pvv, s, sh, sv, ex, ey;
        logic expDe, expE, expHs, expVs;

        // frame 1: colour bars (mode 0), last entry selects ramp for frame 2
        vecs.push_back(pv(1, 2, 10, 2'd0, 16'h0));
        vecs.push_back(av(1, 0, 0,  2'd0, 16'h0, RGB_WHITE));
        vecs.push_back(av(1, 0, 4,  2'd0, 16'h0, RGB_WHITE));
        vecs.push_back(av(1, 0, 5,  2'd0, 16'h0, RGB_YELLOW));
        vecs.push_back(av(1, 0, 10, 2'd0, 16'h0, RGB_CYAN));
        vecs.push_back(av(1, 0, 15, 2'd0, 16'h0, RGB_GREEN));
        vecs.push_back(av(1, 0, 20, 2'd0, 16'h0, RGB_MAGENTA));
        vecs.push_back(av(1, 0, 25, 2'd0, 16'h0, RGB_RED));
        vecs.push_back(av(1, 0, 29, 2'd0, 16'h0, RGB_RED));
        vecs.push_back(av(1, 0, 30, 2'd0, 16'h0, RGB_BLUE));
        vecs.push_back(av(1, 0, 34, 2'd0, 16'h0, RGB_BLUE));
        vecs.push_back(av(1, 0, 35, 2'd0, 16'h0, RGB_BLACK));
        vecs.push_back(av(1, 0, 41, 2'd0, 16'h0, RGB_BLACK));
        vecs.push_back(pv(1, 4, 47, 2'd0, 16'h0));
        vecs.push_back(av(1, 19, 9, 2'd1, 16'h0, RGB_YELLOW));
        // frame 2: gray ramp, last entry selects grid for frame 3
        vecs.push_back(av(2, 5, 0,  2'd1, 16'h0, 16'h0000));
        vecs.push_back(av(2, 5, 4,  2'd1, 16'h0, 16'h0000));
        vecs.push_back(av(2, 5, 16, 2'd1, 16'h0, 16'h0020));
        vecs.push_back(av(2, 5, 28, 2'd1, 16'h0, 16'h0020));
        vecs.push_back(av(2, 5, 32, 2'd1, 16'h0, 16'h0841));
        vecs.push_back(av(2, 5, 36, 2'd1, 16'h0, 16'h0841));
        vecs.push_back(av(2, 5, 41, 2'd2, 16'h0, 16'h0841));
        // frame 3: grid; solid red requested mid-frame must not disturb it
        vecs.push_back(av(3, 0, 5,  2'd2, 16'h0, RGB_WHITE));
        vecs.push_back(av(3, 1, 0,  2'd2, 16'h0, RGB_WHITE));
        vecs.push_back(av(3, 1, 1,  2'd2, 16'h0, RGB_BLACK));
        vecs.push_back(av(3, 1, 7,  2'd2, 16'h0, RGB_BLACK));
        vecs.push_back(av(3, 1, 8,  2'd2, 16'h0, RGB_WHITE));
        vecs.push_back(av(3, 1, 39, 2'd2, 16'h0, RGB_BLACK));
        vecs.push_back(av(3, 1, 41, 2'd2, 16'h0, RGB_WHITE));
        vecs.push_back(av(3, 8, 3,  2'd2, 16'h0, RGB_WHITE));
        vecs.push_back(av(3, 9, 3,  2'd3, 16'hF800, RGB_BLACK));
        vecs.push_back(av(3, 16, 3, 2'd3, 16'hF800, RGB_WHITE));
        vecs.push_back(av(3, 17, 1, 2'd3, 16'hF800, RGB_BLACK));
        vecs.push_back(av(3, 19, 3, 2'd3, 16'hF800, RGB_WHITE));
        // frame 4: solid
        vecs.push_back(pv(4, 0, 0,  2'd3, 16'hF800));
        vecs.push_back(av(4, 0, 0,  2'd3, 16'hF800, RGB_RED));
        vecs.push_back(av(4, 10, 20, 2'd3, 16'hF800, RGB_RED));
        vecs.push_back(av(4, 19, 41, 2'd3, 16'hF800, RGB_RED));
        vecs.push_back(pv(4, 24, 10, 2'd3, 16'hF800));

        // reset state
        applyStimulus(2'd0, 16'h0000);
        RST = 1'b1;
        #12;
        checkOutput("rst_hsync", lcd.LCD_HSYNC, 1);
        checkOutput("rst_vsync", lcd.LCD_VSYNC, 1);
        checkOutput("rst_hsync_inv", lcdInv.LCD_HSYNC, 0);
        checkOutput("rst_vsync_inv", lcdInv.LCD_VSYNC, 0);
        checkOutput("rst_de", lcd.LCD_DE, 0);
        checkOutput("rst_rgb", rgbOf(lcd.LCD_R, lcd.LCD_G, lcd.LCD_B), 0);
        checkOutput("rst_frame_start", lcd.frame_start, 0);
        checkOutput("rst_de_early", lcd.de_early, 0);
        checkOutput("rst_xy", {lcd.x, lcd.y}, 0);
        @(negedge PixelClk);
        RST = 1'b0;
        edgeCnt = 0;

        // frame 0: whole-frame timing statistics
        hsLow = 0; vsLow = 0; hsInvHigh = 0; syncErr = 0; deHigh = 0; run = 0;
        maxRun = 0; lines = 0; rgbBad = 0; fsCnt = 0; deErr = 0; xyErr = 0; deEarlyCnt = 0;
        for (int e = 1; e <= FRAME; e++) begin
            gotoEdge(e);
            p = e - 1; ph = p % HT; pvv = p / HT;
            expDe = (ph >= HA0) && (ph < HA0 + HA) && (pvv >= VA0) && (pvv < VA0 + VA);
            expHs = (ph < HS) ? 1'b0 : 1'b1;
            expVs = (pvv < VS) ? 1'b0 : 1'b1;
            if (lcd.LCD_HSYNC !== expHs || lcd.LCD_VSYNC !== expVs ||
                lcdInv.LCD_HSYNC !== ~expHs || lcdInv.LCD_VSYNC !== ~expVs) syncErr++;
            if (lcd.LCD_HSYNC == 1'b0) hsLow++;
            if (lcd.LCD_VSYNC == 1'b0) vsLow++;
            if (lcdInv.LCD_HSYNC == 1'b1) hsInvHigh++;
            if (lcd.LCD_DE !== expDe) deErr++;
            if (lcd.LCD_DE) begin
                run++; deHigh++;
            end else begin
                if (run > 0) lines++;
                if (run > maxRun) maxRun = run;
                run = 0;
            end
            if (!lcd.LCD_DE && rgbOf(lcd.LCD_R, lcd.LCD_G, lcd.LCD_B) != 16'h0) rgbBad++;
            if (lcd.frame_start) fsCnt++;
            if (e == 1 && lcd.frame_start !== 1'b1) fsCnt = -100;
            s = e % FRAME; sh = s % HT; sv = s / HT;
            expE = (sh >= HA0) && (sh < HA0 + HA) && (sv >= VA0) && (sv < VA0 + VA);
            ex = expE ? sh - HA0 : 0;
            ey = expE ? sv - VA0 : 0;
            if (lcd.de_early !== expE || lcd.x !== CW'(ex) || lcd.y !== CW'(ey)) xyErr++;
            if (lcd.de_early) deEarlyCnt++;
        end
        checkOutput("hsync_low_cycles", hsLow, HS * VT);
        checkOutput("vsync_low_cycles", vsLow, VS * HT);
        checkOutput("hsync_inv_high_cycles", hsInvHigh, HS * VT);
        checkOutput("sync_position_errors", syncErr, 0);
        checkOutput("de_high_cycles", deHigh, HA * VA);
        checkOutput("de_max_run", maxRun, HA);
        checkOutput("de_lines", lines, VA);
        checkOutput("de_position_errors", deErr, 0);
        checkOutput("rgb_outside_de", rgbBad, 0);
        checkOutput("frame_start_count", fsCnt, 1);
        checkOutput("de_early_xy_errors", xyErr, 0);
        checkOutput("de_early_cycles", deEarlyCnt, HA * VA);

        gotoEdge(FRAME + 1);
        checkOutput("frame_start_period", lcd.frame_start, 1);
        gotoEdge(FRAME + 2);
        checkOutput("frame_start_one_cycle", lcd.frame_start, 0);

        // table-driven pattern vectors, frames 1..4
        foreach (vecs[i]) begin
            gotoEdge(vecs[i].pos + 1);
            checkOutput($sformatf("vec%0d_rgb", i), rgbOf(lcd.LCD_R, lcd.LCD_G, lcd.LCD_B), vecs[i].expRgb);
            checkOutput($sformatf("vec%0d_de", i), lcd.LCD_DE, vecs[i].expDe);
            applyStimulus(vecs[i].nextMode, vecs[i].nextSolid);
        end

        // asynchronous reset in the middle of an active line of frame 5
        gotoEdge(5 * FRAME + 10 * HT + 30);
        checkOutput("pre_reset_de_early", lcd.de_early, 1);
        checkOutput("pre_reset_de", lcd.LCD_DE, 1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async_rst_de", lcd.LCD_DE, 0);
        checkOutput("async_rst_rgb", rgbOf(lcd.LCD_R, lcd.LCD_G, lcd.LCD_B), 0);
        checkOutput("async_rst_hsync", lcd.LCD_HSYNC, 1);
        checkOutput("async_rst_vsync", lcd.LCD_VSYNC, 1);
        checkOutput("async_rst_vsync_inv", lcdInv.LCD_VSYNC, 0);
        checkOutput("async_rst_de_early", lcd.de_early, 0);
        checkOutput("async_rst_xy", {lcd.x, lcd.y}, 0);
        checkOutput("async_rst_frame_start", lcd.frame_start, 0);
        repeat (3) @(posedge PixelClk);
        @(negedge PixelClk);
        RST = 1'b0;
        edgeCnt = 0;
        gotoEdge(1);
        checkOutput("post_rst_frame_start", lcd.frame_start, 1);
        checkOutput("post_rst_x", lcd.x, 0);
        gotoEdge(2);
        checkOutput("post_rst_frame_start_clear", lcd.frame_start, 0);
        gotoEdge(VA0 * HT + HA0 + 1);
        checkOutput("post_rst_solid", rgbOf(lcd.LCD_R, lcd.LCD_G, lcd.LCD_B), RGB_RED);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
